// File: rtl/spi_reg_bank.sv
// SPI-facing register bank: double-buffered control words with atomic commit,
// on-demand status snapshots and a saturating illegal-write counter.
module spi_reg_bank #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 8,
    parameter int NUM_STATUS = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [6:0]                       addr,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic                             wr_en,
    output logic [DATA_WIDTH-1:0]            data_out,
    input  logic [NUM_STATUS*DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0]   ctrl_out,
    output logic                             commit_pulse
);

    localparam logic [6:0] ADDR_SNAP   = 7'h7D;
    localparam logic [6:0] ADDR_BADCNT = 7'h7E;
    localparam logic [6:0] ADDR_COMMIT = 7'h7F;

    logic [DATA_WIDTH-1:0] shadow [NUM_REGS];
    logic [DATA_WIDTH-1:0] live   [NUM_REGS];
    logic [DATA_WIDTH-1:0] snap   [NUM_STATUS];
    logic [7:0]            badcnt;
    logic                  commit_pend;
    logic                  hit_shadow;
    logic                  bad_write;
    logic                  commit_req;
    logic [DATA_WIDTH-1:0] rd_data;

    always_comb begin
        hit_shadow = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (addr == 7'(k)) hit_shadow = 1'b1;
        end
    end

    assign commit_req = wr_en && (addr == ADDR_COMMIT) && data_in[0];
    assign bad_write  = wr_en && !hit_shadow && (addr != ADDR_SNAP)
                        && (addr != ADDR_BADCNT) && (addr != ADDR_COMMIT);

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (addr == 7'(k))      rd_data = shadow[k];
            if (addr == 7'(32 + k)) rd_data = live[k];
        end
        for (int k = 0; k < NUM_STATUS; k++) begin
            if (addr == 7'(64 + k)) rd_data = snap[k];
        end
        if (addr == ADDR_BADCNT) rd_data = DATA_WIDTH'(badcnt);
    end

    // Shadows cannot change on the strobe edge itself (that write targets COMMIT),
    // so copying them one edge later still yields the pre-strobe values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                shadow[k] <= '0;
                live[k]   <= '0;
            end
            commit_pend  <= 1'b0;
            commit_pulse <= 1'b0;
        end else begin
            commit_pend  <= commit_req;
            commit_pulse <= commit_pend;
            if (commit_pend) begin
                for (int k = 0; k < NUM_REGS; k++) live[k] <= shadow[k];
            end
            if (wr_en) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (addr == 7'(k)) shadow[k] <= data_in;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_STATUS; k++) snap[k] <= '0;
            badcnt   <= '0;
            data_out <= '0;
        end else begin
            if (wr_en && (addr == ADDR_SNAP)) begin
                for (int k = 0; k < NUM_STATUS; k++) begin
                    snap[k] <= status_in[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (wr_en && (addr == ADDR_BADCNT)) begin
                badcnt <= '0;
            end else if (bad_write && (badcnt != 8'hFF)) begin
                badcnt <= badcnt + 8'd1;
            end
            data_out <= rd_data;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctrl
        assign ctrl_out[g*DATA_WIDTH +: DATA_WIDTH] = live[g];
    end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Register bank directly downstream of the SPI slave front end. Consumes its address, write data and write-strobe outputs, and returns read data for the next transaction.
- Holds NUM_REGS double-buffered control words. SPI writes land in shadow registers; a commit write atomically copies all shadows to the live ctrl outputs.
- Also provides on-demand snapshots of a status input bus and a saturating counter of illegal writes.

Parameters:
- DATA_WIDTH, 64: word width. Must match the SPI slave data register length.
- NUM_REGS, 8: number of control registers, 1..32.
- NUM_STATUS, 4: number of status words, 1..32.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- addr  input  7  register address from the SPI slave.
- data_in  input  DATA_WIDTH  write data; valid while wr_en is high.
- wr_en  input  1  single-cycle write strobe.
- data_out  output  DATA_WIDTH  registered read data for addr.
- status_in  input  NUM_STATUS*DATA_WIDTH  status words; word k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]. Synchronous to clk.
- ctrl_out  output  NUM_REGS*DATA_WIDTH  live (committed) control words, same packing as status_in.
- commit_pulse  output  1  high for one cycle when ctrl_out takes new values.

Behaviour:
- Address map:
  - 0x00..NUM_REGS-1: shadow registers, read/write.
  - 0x20..0x20+NUM_REGS-1: live registers, read-only.
  - 0x40..0x40+NUM_STATUS-1: status snapshot, read-only.
  - 0x7D: SNAP. A write of any data copies all of status_in into the snapshot. Reads return 0.
  - 0x7E: BADCNT. Reads return the 8-bit count, zero-extended. A write of any data clears the count.
  - 0x7F: COMMIT. A write with data_in[0]=1 commits. Reads return 0.
  - All other addresses read 0.
- Reset, asynchronous and taking priority over everything:
  - all shadow, live and snapshot registers = 0
  - BADCNT = 0
  - data_out = 0
  - commit_pulse = 0
- Write (wr_en=1 at edge N):
  - The target register updates at edge N. data_in is sampled only when wr_en=1.
  - SNAP: the snapshot holds the status_in value sampled at edge N.
- Commit:
  - COMMIT write with data_in[0]=1 at edge N: ctrl_out equals all shadows as of before edge N, and is visible after edge N+1.
  - commit_pulse is high for exactly the cycle between edges N+1 and N+2.
  - A COMMIT write with data_in[0]=0 is a no-op and is not counted as bad.
  - Shadow writes after the commit strobe do not affect that commit.
- Bad write: a write to a read-only or unmapped address changes no register and increments BADCNT.
  - BADCNT saturates at 255; further bad writes hold 255.
  - A write to BADCNT clears it and is never counted.
- Read path: data_out is registered. data_out after edge M reflects addr and register contents sampled at edge M.
  - A write at edge N is visible in data_out after edge N+1 if addr is unchanged.
  - data_out updates every cycle regardless of wr_en.
- Consecutive wr_en pulses on back-to-back cycles are each applied independently.
- Reset asserted mid-commit: commit_pulse drops immediately and ctrl_out goes to 0.

Test Plan:
- After reset, read addresses 0x00, 0x20, 0x40 and 0x7E -> all data_out = 0; ctrl_out = 0; commit_pulse = 0.
- Write 0x1122334455667788 to 0x03, then read 0x03 and 0x23 -> 0x1122334455667788 and 0, respectively. ctrl_out word 3 stays 0.
- Write 0x01 to 0x7F -> one cycle later ctrl_out word 3 = 0x1122334455667788 and commit_pulse is high for exactly 1 cycle. Read 0x23 -> 0x1122334455667788. Writing 0x00 to 0x7F produces no pulse.
- Drive status_in word 1 = 0xDEADBEEF, write 0x7D, then change status_in -> read 0x41 returns 0xDEADBEEF.
- Write 300 times to 0x20 -> BADCNT reads 255 and live registers are unchanged. Write to 0x7E -> BADCNT reads 0.
- Assert rst in the cycle commit_pulse is high -> commit_pulse = 0 and ctrl_out = 0 immediately. Issue shadow writes on consecutive cycles -> both values are retained.
